// File: rtl/byte_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : byte_serial_adder
// Description : Performs one NUM_BYTES*8-bit addition as NUM_BYTES passes
//               through an external 8-bit adder, least-significant byte
//               first, carrying between passes.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_serial_adder #(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] a_in,
    input  logic [8*NUM_BYTES-1:0] b_in,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [8*NUM_BYTES-1:0] sum_out,
    output logic                   cout_out,
    output logic [7:0]             add_a,
    output logic [7:0]             add_b,
    output logic                   add_cin,
    input  logic [7:0]             add_sum,
    input  logic                   add_cout
);

    // idx carries one spare bit so it never wraps within an operation
    localparam int c_IDXW = $clog2(NUM_BYTES) + 1;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_IDXW-1:0]      r_idx;
    logic                   r_carry;
    logic [8*NUM_BYTES-1:0] r_a;
    logic [8*NUM_BYTES-1:0] r_b;
    logic [8*NUM_BYTES-1:0] r_sum;
    logic                   r_cout;
    logic                   w_accept;
    logic                   w_last;
    logic [7:0]             w_add_a;
    logic [7:0]             w_add_b;

    // start is only honoured when the sequencer is idle or just finishing
    assign w_accept = start && ((r_state == c_S_IDLE) || (r_state == c_S_DONE));
    assign w_last   = (r_idx == c_IDXW'(NUM_BYTES - 1));

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (start) w_state_nxt = c_S_RUN;
            c_S_RUN:  if (w_last) w_state_nxt = c_S_DONE;
            c_S_DONE: w_state_nxt = start ? c_S_RUN : c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, per-byte result capture and carry propagation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_carry <= cin;
            r_idx   <= '0;
        end else if (r_state == c_S_RUN) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (r_idx == c_IDXW'(i)) r_sum[i*8 +: 8] <= add_sum;
            end
            r_carry <= add_cout;
            r_idx   <= r_idx + c_IDXW'(1);
            if (w_last) r_cout <= add_cout;
        end
    end

    // Adder operands come from registered state only; zero outside RUN
    always_comb begin
        w_add_a = 8'h00;
        w_add_b = 8'h00;
        if (r_state == c_S_RUN) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (r_idx == c_IDXW'(i)) begin
                    w_add_a = r_a[i*8 +: 8];
                    w_add_b = r_b[i*8 +: 8];
                end
            end
        end
    end

    assign add_a    = w_add_a;
    assign add_b    = w_add_b;
    assign add_cin  = (r_state == c_S_RUN) ? r_carry : 1'b0;
    assign busy     = (r_state == c_S_RUN);
    assign done     = (r_state == c_S_DONE);
    assign sum_out  = r_sum;
    assign cout_out = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_byte_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_serial_adder
// Description : Self-checking bench for byte_serial_adder (4-byte and
//               1-byte instances, each with its own 8-bit adder).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_serial_adder;

    logic clk;
    logic rst_n;

    // 4-byte instance
    logic        r_start4, r_cin4;
    logic [31:0] r_a4, r_b4;
    logic        w_busy4, w_done4, w_cout4, w_acin4, w_acout4;
    logic [31:0] w_sum4;
    logic [7:0]  w_aa4, w_ab4, w_asum4;

    // 1-byte instance
    logic        r_start1, r_cin1;
    logic [7:0]  r_a1, r_b1;
    logic        w_busy1, w_done1, w_cout1, w_acin1, w_acout1;
    logic [7:0]  w_sum1;
    logic [7:0]  w_aa1, w_ab1, w_asum1;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] es;
        logic        ec;
    } vec_t;

    vec_t vecs[6];

    // External 8-bit adders
    assign {w_acout4, w_asum4} = {1'b0, w_aa4} + {1'b0, w_ab4} + {8'h00, w_acin4};
    assign {w_acout1, w_asum1} = {1'b0, w_aa1} + {1'b0, w_ab1} + {8'h00, w_acin1};

    byte_serial_adder #(.NUM_BYTES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(r_start4), .a_in(r_a4), .b_in(r_b4),
        .cin(r_cin4), .busy(w_busy4), .done(w_done4), .sum_out(w_sum4),
        .cout_out(w_cout4), .add_a(w_aa4), .add_b(w_ab4), .add_cin(w_acin4),
        .add_sum(w_asum4), .add_cout(w_acout4)
    );

    byte_serial_adder #(.NUM_BYTES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(r_start1), .a_in(r_a1), .b_in(r_b1),
        .cin(r_cin1), .busy(w_busy1), .done(w_done1), .sum_out(w_sum1),
        .cout_out(w_cout1), .add_a(w_aa1), .add_b(w_ab1), .add_cin(w_acin1),
        .add_sum(w_asum1), .add_cout(w_acout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Runs one 4-byte add starting at the current negedge; returns at the
    // negedge where done is seen (b2b=1) or one cycle later (b2b=0).
    task automatic op4(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic [31:0] es, input logic ec, input bit b2b, input string nm);
        int n;
        bit seq_ok;
        r_start4 = 1'b1; r_a4 = a; r_b4 = b; r_cin4 = c;
        @(negedge clk);
        r_start4 = 1'b0; r_a4 = $urandom; r_b4 = $urandom; r_cin4 = 1'($urandom);
        n = 1;
        seq_ok = 1'b1;
        while (!w_done4 && n < 20) begin
            if (n <= 4) begin
                if (!w_busy4 || w_aa4 !== a[(n-1)*8 +: 8] || w_ab4 !== b[(n-1)*8 +: 8])
                    seq_ok = 1'b0;
                if (n == 1 && w_acin4 !== c) seq_ok = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'd5);
        chk({nm, "_sum"}, 64'(w_sum4), 64'(es));
        chk({nm, "_cout"}, 64'(w_cout4), 64'(ec));
        chk({nm, "_addseq"}, 64'(seq_ok), 64'd1);
        if (!b2b) begin
            @(negedge clk);
            chk({nm, "_donepulse"}, 64'({w_done4, w_busy4}), 64'd0);
        end
    endtask

    // One 1-byte add; RUN lasts one cycle so done follows two edges later
    task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic c, input string nm);
        int n;
        logic [8:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {8'h00, c};
        r_start1 = 1'b1; r_a1 = a; r_b1 = b; r_cin1 = c;
        @(negedge clk);
        r_start1 = 1'b0;
        n = 1;
        while (!w_done1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'd2);
        chk({nm, "_sum"}, 64'(w_sum1), 64'(exp[7:0]));
        chk({nm, "_cout"}, 64'(w_cout1), 64'(exp[8]));
        @(negedge clk);
    endtask

    initial begin
        logic [32:0] ref_sum;
        logic [31:0] ra, rb;
        logic        rc;
        int          pulses;
        logic [31:0] seen;

        checks = 0;
        failures = 0;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[1] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0};
        vecs[2] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        vecs[5] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};

        r_start4 = 1'b0; r_a4 = '0; r_b4 = '0; r_cin4 = 1'b0;
        r_start1 = 1'b0; r_a1 = '0; r_b1 = '0; r_cin1 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_busy", 64'(w_busy4), 64'd0);
        chk("rst_done", 64'(w_done4), 64'd0);
        chk("rst_sum", 64'(w_sum4), 64'd0);
        chk("rst_cout", 64'(w_cout4), 64'd0);
        chk("rst_addbus", 64'({w_aa4, w_ab4, w_acin4}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_addbus", 64'({w_aa4, w_ab4, w_acin4, w_busy4}), 64'd0);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            op4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].es, vecs[i].ec, 1'b0,
                $sformatf("vec%0d", i));
        end

        // start during RUN cycle 2 is ignored
        r_start4 = 1'b1; r_a4 = 32'h01020304; r_b4 = 32'h10203040; r_cin4 = 1'b0;
        @(negedge clk);
        r_start4 = 1'b0;
        @(negedge clk);
        r_start4 = 1'b1; r_a4 = 32'hAAAAAAAA; r_b4 = 32'h55555555; r_cin4 = 1'b1;
        @(negedge clk);
        r_start4 = 1'b0;
        pulses = 0;
        seen = '0;
        for (int k = 0; k < 12; k++) begin
            if (w_done4) begin
                pulses++;
                seen = w_sum4;
            end
            @(negedge clk);
        end
        chk("ignore_pulses", 64'(pulses), 64'd1);
        chk("ignore_sum", 64'(seen), 64'h11223344);

        // Back-to-back: start held in the done cycle
        op4(32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b1, "b2b_first");
        op4(32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0, "b2b_second");

        // Reset during RUN cycle 3
        op4(32'h89ABCDEF, 32'h89ABCDEF, 1'b0, 32'h13579BDE, 1'b1, 1'b0, "pre_rst");
        r_start4 = 1'b1; r_a4 = 32'hFFFFFFFF; r_b4 = 32'hFFFFFFFF; r_cin4 = 1'b1;
        @(negedge clk);
        r_start4 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", 64'({w_busy4, w_done4, w_cout4}), 64'd0);
        chk("midrst_sum", 64'(w_sum4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (w_done4 || w_busy4) pulses++;
        end
        chk("midrst_nodone", 64'(pulses), 64'd0);

        // Randomised against arithmetic model
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? ~ra : $urandom;
            rc = 1'($urandom);
            ref_sum = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            op4(ra, rb, rc, ref_sum[31:0], ref_sum[32], (i % 3 == 0),
                $sformatf("rnd%0d", i));
        end
        repeat (2) @(negedge clk);

        // Single-byte instance
        op1(8'h80, 8'h80, 1'b1, "nb1_corner");
        for (int i = 0; i < 6; i++) begin
            op1(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("nb1_rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
